// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, times out and retries a PLL that
// fails to lock, and releases a synchronous system reset once lock is stable.
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned STABLE_CYCLES       = 1024,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       lock_lost,
  output logic       lock_fail,
  output logic [3:0] retry_count
);

  localparam int unsigned PW = $clog2(RST_PULSE_CYCLES + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned RW = 4;

  typedef enum logic [2:0] {
    PLL_RESET   = 3'd0,
    WAIT_LOCK   = 3'd1,
    STABLE_WAIT = 3'd2,
    RUN         = 3'd3,
    FAIL        = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [TW-1:0] timeout_cnt_q, timeout_cnt_d;
  logic [SW-1:0] stable_cnt_q, stable_cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          meta_q, locked_s_q;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_reset_q, sys_reset_d;
  logic          lock_lost_q, lock_lost_d;
  logic          lock_fail_q, lock_fail_d;
  logic          locked_s;

  assign locked_s = locked_s_q;

  // Next state, counters, and registered outputs derived from the next state.
  always_comb begin
    state_d       = state_q;
    pulse_cnt_d   = pulse_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    stable_cnt_d  = stable_cnt_q;
    retry_d       = retry_q;
    lock_lost_d   = 1'b0;

    case (state_q)
      PLL_RESET: begin
        if (pulse_cnt_q >= PW'(RST_PULSE_CYCLES - 1)) begin
          state_d       = WAIT_LOCK;
          timeout_cnt_d = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PW'(1);
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d      = STABLE_WAIT;
          stable_cnt_d = '0;
        end else if (timeout_cnt_q >= TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          if (retry_q >= RW'(MAX_RETRIES)) begin
            state_d = FAIL;
          end else begin
            retry_d     = retry_q + RW'(1);
            state_d     = PLL_RESET;
            pulse_cnt_d = '0;
          end
        end else begin
          timeout_cnt_d = timeout_cnt_q + TW'(1);
        end
      end
      STABLE_WAIT: begin
        // A dropout restarts the lock wait without spending a retry.
        if (!locked_s) begin
          state_d       = WAIT_LOCK;
          timeout_cnt_d = '0;
        end else if (stable_cnt_q >= SW'(STABLE_CYCLES - 1)) begin
          state_d = RUN;
          retry_d = '0;
        end else begin
          stable_cnt_d = stable_cnt_q + SW'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d     = PLL_RESET;
          pulse_cnt_d = '0;
          lock_lost_d = 1'b1;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d     = PLL_RESET;
        pulse_cnt_d = '0;
      end
    endcase

    pll_rst_d   = (state_d == PLL_RESET);
    sys_reset_d = (state_d != RUN);
    lock_fail_d = (state_d == FAIL);
  end

  // State, synchronizer and output registers; rst overrides everything.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q       <= PLL_RESET;
      pulse_cnt_q   <= '0;
      timeout_cnt_q <= '0;
      stable_cnt_q  <= '0;
      retry_q       <= '0;
      meta_q        <= 1'b0;
      locked_s_q    <= 1'b0;
      pll_rst_q     <= 1'b1;
      sys_reset_q   <= 1'b1;
      lock_lost_q   <= 1'b0;
      lock_fail_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pulse_cnt_q   <= pulse_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      stable_cnt_q  <= stable_cnt_d;
      retry_q       <= retry_d;
      meta_q        <= pll_locked;
      locked_s_q    <= meta_q;
      pll_rst_q     <= pll_rst_d;
      sys_reset_q   <= sys_reset_d;
      lock_lost_q   <= lock_lost_d;
      lock_fail_q   <= lock_fail_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_reset   = sys_reset_q;
  assign lock_lost   = lock_lost_q;
  assign lock_fail   = lock_fail_q;
  assign retry_count = retry_q;

endmodule
